mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: WIDTH, 32, data and address-operand width in bits.
REQ-002 Parameter: DEPTH, 256, number of words in the data memory.
REQ-003 Clocking: one clock, clk; reset is synchronous and active-high.
REQ-004 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: rst  input  1  synchronous, active-high reset.
REQ-006 Port: SelectMem  input  1  write-back source select; 1 = memory read data, 0 = ALURESULT pass-through.
REQ-007 Port: WE  input  1  memory write enable.
REQ-008 Port: ALURESULT  input  WIDTH  word address for the memory access, and also the pass-through value.
REQ-009 Port: Data2  input  WIDTH  store data.
REQ-010 Port: Data5  output  WIDTH  registered stage result.

Function
REQ-011 The memory SHALL be DEPTH words of WIDTH bits, word-addressed; ALURESULT value N selects word N, with no byte offset.
REQ-012 An address is in range when ALURESULT < DEPTH; the index is ALURESULT[$clog2(DEPTH)-1:0].
REQ-013 Write: at the rising edge with WE=1, rst=0 and the address in range, mem[ALURESULT] SHALL take Data2.
REQ-014 Writes to out-of-range addresses SHALL be ignored, with no memory change.
REQ-015 Read data SHALL be mem[ALURESULT] when the address is in range, and 0 otherwise.
REQ-016 Data5 SHALL update every rising edge with rst=0: SelectMem=1 loads the read data; SelectMem=0 loads ALURESULT.
REQ-017 Latency: Data5 SHALL reflect the inputs sampled at the previous rising edge (1-cycle latency); there is no handshake.
REQ-018 Read-during-write to the same address in the same cycle SHALL return the old (pre-write) data; the new data is visible from the next cycle.
REQ-019 WE and SelectMem SHALL be independent; both at 1 performs the write and the old-data read in the same cycle.
REQ-020 A write SHALL occur whatever the value of SelectMem.
REQ-021 Data5 SHALL never be driven with X after reset; unwritten words read as 0.

Reset
REQ-022 With rst=1 at a rising edge, Data5 SHALL become 0.
REQ-023 With rst=1, all memory words SHALL be cleared to 0; the implementation may clear them over that edge or keep a per-word valid bit cleared at that edge.
REQ-024 Reset SHALL take priority over WE: no write occurs while rst=1.
REQ-025 Reset asserted mid-operation SHALL discard any write pending in that cycle.
REQ-026 Before the first reset, the state is undefined.

Structure
REQ-027 Package mem_stage_pkg SHALL hold WIDTH, DEPTH, ADDR_W = $clog2(DEPTH), and a data_t typedef (logic [WIDTH-1:0]).
REQ-028 Sub-module data_ram SHALL hold the storage, the range check, the write port, the read port and the reset clear.
REQ-029 The top level SHALL hold only the SelectMem mux and the Data5 register.

Verification
REQ-030 Reset, then SelectMem=1, ALURESULT=8 -> Data5=0 after 1 clock.
REQ-031 WE=1, ALURESULT=8, Data2=3 for one edge, then WE=0, SelectMem=1, ALURESULT=8 -> Data5=3; address 9 still reads 0.
REQ-032 SelectMem=0, WE=0, ALURESULT=9, Data2=4 -> Data5=9 after 1 clock; memory unchanged, so a later read of address 9 returns 0.
REQ-033 mem[8]=3, then WE=1, SelectMem=1, ALURESULT=8, Data2=7 -> Data5=3 at that edge, and Data5=7 on the following read.
REQ-034 WE=1, ALURESULT=300, Data2=5 -> no write; reading 300 gives Data5=0, and reading 300 mod 256 = 44 also gives 0.
REQ-035 mem[8]=3, then rst=1 together with WE=1, Data2=9 -> Data5=0, and reading address 8 afterwards gives 0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared sizing and types for the memory stage.
package mem_stage_pkg;

   localparam int WIDTH  = 32;
   localparam int DEPTH  = 256;
   localparam int ADDR_W = $clog2(DEPTH);

   typedef logic [WIDTH-1:0]  data_t;
   typedef logic [ADDR_W-1:0] addr_t;

   // Word address lies inside the data memory.
   function automatic logic in_range(data_t addr);
      return addr < data_t'(DEPTH);
   endfunction

   // Low address bits used to index the data memory.
   function automatic addr_t to_index(data_t addr);
      return addr[ADDR_W-1:0];
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Operand and result signals of the memory stage.
interface mem_stage_if;
   import mem_stage_pkg::*;

   logic  SelectMem;
   logic  WE;
   data_t ALURESULT;
   data_t Data2;
   data_t Data5;

   // Driver side (previous stage / testbench).
   modport master (
      output SelectMem, WE, ALURESULT, Data2,
      input  Data5
   );

   // Memory stage side.
   modport slave (
      input  SelectMem, WE, ALURESULT, Data2,
      output Data5
   );

endinterface

// File: rtl/mem_stage_data_ram.sv
// Word-addressed data memory: range check, write port, asynchronous read
// port, and a per-word valid bit that makes reset clear every word at once.
module data_ram
   import mem_stage_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  we,
   input  data_t addr,
   input  data_t wdata,
   output data_t rdata
);

   data_t            mem [DEPTH];
   logic [DEPTH-1:0] valid;
   logic             hit;
   addr_t            idx;

   assign hit = in_range(addr);
   assign idx = to_index(addr);

   // Valid bits: cleared by reset, set by an in-range write.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (rst)
         valid <= '0;
      else if (we && hit)
         valid[idx] <= 1'b1;
   end

   // Storage array write port; reset suppresses any pending write.
   // NOTE: the array itself is never reset -- the valid bits above mask
   // stale contents, so the storage can map onto plain RAM.
   always_ff @(posedge clk) begin
      if (!rst && we && hit)
         mem[idx] <= wdata;
   end

   // Read port: returns pre-write contents; out-of-range or unwritten words read 0.
   // NOTE: the output gets a default first so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      rdata = '0;
      if (hit && valid[idx])
         rdata = mem[idx];
   end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: write-back source mux and the registered stage result.
module mem_stage
   import mem_stage_pkg::*;
(
   input logic        clk,
   input logic        rst,
   mem_stage_if.slave bus
);

   data_t rdata;
   data_t wb_data;
   data_t data5_q;

   data_ram u_data_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (bus.WE),
      .addr  (bus.ALURESULT),
      .wdata (bus.Data2),
      .rdata (rdata)
   );

   // Write-back source select: memory read data or ALU pass-through.
   always_comb begin
      wb_data = bus.ALURESULT;
      if (bus.SelectMem)
         wb_data = rdata;
   end

   // Stage result register, one cycle behind the inputs.
   always_ff @(posedge clk) begin
      if (rst)
         data5_q <= '0;
      else
         data5_q <= wb_data;
   end

   assign bus.Data5 = data5_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   mem_stage_if bus ();

   mem_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge, then settle so outputs are sampled off the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input data_t obs, input data_t exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic sel, input logic we, input data_t addr, input data_t wd);
      bus.SelectMem = sel;
      bus.WE        = we;
      bus.ALURESULT = addr;
      bus.Data2     = wd;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;

      // Reset state
      rst = 1'b1;
      drive(1'b0, 1'b0, 32'd0, 32'd0);
      step();
      step();
      check("reset_data5", bus.Data5, 32'd0);

      // Unwritten word reads 0
      rst = 1'b0;
      drive(1'b1, 1'b0, 32'd8, 32'd0);
      step();
      check("read_unwritten_8", bus.Data5, 32'd0);

      // Write mem[8]=3 while passing the address through
      drive(1'b0, 1'b1, 32'd8, 32'd3);
      step();
      check("write8_passthru", bus.Data5, 32'd8);

      drive(1'b1, 1'b0, 32'd8, 32'd0);
      step();
      check("read8_after_write", bus.Data5, 32'd3);

      drive(1'b1, 1'b0, 32'd9, 32'd0);
      step();
      check("read9_untouched", bus.Data5, 32'd0);

      // Pass-through with WE=0 does not touch memory
      drive(1'b0, 1'b0, 32'd9, 32'd4);
      step();
      check("passthru_9", bus.Data5, 32'd9);

      drive(1'b1, 1'b0, 32'd9, 32'd0);
      step();
      check("read9_no_write", bus.Data5, 32'd0);

      // Read-during-write returns old data, new data next cycle
      drive(1'b1, 1'b1, 32'd8, 32'd7);
      step();
      check("rdw_old_data", bus.Data5, 32'd3);

      drive(1'b1, 1'b0, 32'd8, 32'd0);
      step();
      check("rdw_new_data", bus.Data5, 32'd7);

      // Out-of-range write ignored, no aliasing onto 300 mod 256
      drive(1'b1, 1'b1, 32'd300, 32'd5);
      step();
      check("oor_write_read", bus.Data5, 32'd0);

      drive(1'b1, 1'b0, 32'd300, 32'd0);
      step();
      check("oor_read_300", bus.Data5, 32'd0);

      drive(1'b1, 1'b0, 32'd44, 32'd0);
      step();
      check("alias_read_44", bus.Data5, 32'd0);

      // Top word of memory, and the first address past it
      drive(1'b0, 1'b1, 32'd255, 32'h0000_a5a5);
      step();
      check("write255_passthru", bus.Data5, 32'd255);

      drive(1'b1, 1'b0, 32'd255, 32'd0);
      step();
      check("read255", bus.Data5, 32'h0000_a5a5);

      drive(1'b1, 1'b0, 32'd256, 32'd0);
      step();
      check("read256_oor", bus.Data5, 32'd0);

      // Full-width pass-through
      drive(1'b0, 1'b0, 32'hdead_beef, 32'd0);
      step();
      check("passthru_wide", bus.Data5, 32'hdead_beef);

      // Reset with pending write: write discarded, memory cleared
      drive(1'b0, 1'b1, 32'd8, 32'd3);
      step();
      check("rewrite8_passthru", bus.Data5, 32'd8);

      rst = 1'b1;
      drive(1'b1, 1'b1, 32'd8, 32'd9);
      step();
      check("reset_mid_op", bus.Data5, 32'd0);

      rst = 1'b0;
      drive(1'b1, 1'b0, 32'd8, 32'd0);
      step();
      check("read8_after_reset", bus.Data5, 32'd0);

      drive(1'b1, 1'b0, 32'd255, 32'd0);
      step();
      check("read255_after_reset", bus.Data5, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
